// File: rtl/inst_buffer_dual_pkg.sv
// Shared definitions for the dual-issue instruction buffer: the stored entry
// layout and the fetch-side exception cause codes (same values as csr_defines).
package inst_buffer_dual_pkg;

    localparam int PC_W    = 32;
    localparam int INST_W  = 32;
    localparam int CAUSE_W = 7;

    // Fetch-side exception cause codes, kept identical to the CSR ECODE values
    localparam logic [CAUSE_W-1:0] EXCEPTION_PIF  = 7'h03;
    localparam logic [CAUSE_W-1:0] EXCEPTION_PPI  = 7'h07;
    localparam logic [CAUSE_W-1:0] EXCEPTION_ADEF = 7'h08;
    localparam logic [CAUSE_W-1:0] EXCEPTION_TLBR = 7'h3f;

    // One queued instruction, 72 bits wide
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INST_W-1:0]  inst;
        logic               exc;
        logic [CAUSE_W-1:0] cause;
    } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer_dual_if.sv
// Fetch-side, decode-side and flush signals of the instruction buffer.
// The master is the pipeline around the buffer; the slave is the buffer itself.
interface inst_buffer_dual_if;

    logic        flush;
    logic [1:0]  fetch_valid;
    logic [31:0] fetch_pc0;
    logic [31:0] fetch_pc1;
    logic [31:0] fetch_inst0;
    logic [31:0] fetch_inst1;
    logic        fetch_exc0;
    logic        fetch_exc1;
    logic [6:0]  fetch_cause0;
    logic [6:0]  fetch_cause1;
    logic        ibuf_ready;
    logic [1:0]  deq_en;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic        out_exc0;
    logic        out_exc1;
    logic [6:0]  out_cause0;
    logic [6:0]  out_cause1;

    modport master (
        output flush, fetch_valid, fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1,
               fetch_exc0, fetch_exc1, fetch_cause0, fetch_cause1, deq_en,
        input  ibuf_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
               out_exc0, out_exc1, out_cause0, out_cause1
    );

    modport slave (
        input  flush, fetch_valid, fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1,
               fetch_exc0, fetch_exc1, fetch_cause0, fetch_cause1, deq_en,
        output ibuf_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
               out_exc0, out_exc1, out_cause0, out_cause1
    );

endinterface

// File: rtl/inst_buffer_dual_ibuf_entry_ram.sv
// Entry storage for the instruction buffer: a plain register array with two
// write ports and two combinational read ports. The two write addresses are
// always distinct in use, so no write-collision handling is needed.
module ibuf_entry_ram
    import inst_buffer_dual_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr0_en,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  ibuf_entry_t       wr0_data,
    input  logic              wr1_en,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  ibuf_entry_t       wr1_data,
    input  logic [ADDR_W-1:0] rd0_addr,
    output ibuf_entry_t       rd0_data,
    input  logic [ADDR_W-1:0] rd1_addr,
    output ibuf_entry_t       rd1_data
);

    ibuf_entry_t mem [DEPTH];

    // Contents need no reset: entries are only read once counted as valid
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
    end

    assign rd0_data = mem[rd0_addr];
    assign rd1_data = mem[rd1_addr];

endmodule

// File: rtl/inst_buffer_dual.sv
// Dual-issue instruction queue between fetch and the per-slot decoders.
// Up to two instructions enter and leave per cycle; flush empties it at once.
module inst_buffer_dual
    import inst_buffer_dual_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    inst_buffer_dual_if.slave bus
);

    logic [ADDR_W-1:0] head;
    logic [ADDR_W-1:0] tail;
    logic [ADDR_W:0]   count;
    logic              ready;
    logic [1:0]        valid;
    logic              wr0_en;
    logic              wr1_en;
    logic [ADDR_W-1:0] wr1_addr;
    logic [ADDR_W-1:0] head_p1;
    logic [1:0]        push_n;
    logic [1:0]        pop_n;
    ibuf_entry_t       slot0_entry;
    ibuf_entry_t       slot1_entry;
    ibuf_entry_t       rd0;
    ibuf_entry_t       rd1;

    // Room for a full fetch pair is judged only from the registered count
    assign ready   = count <= (ADDR_W+1)'(DEPTH - 2);
    assign valid   = {count >= (ADDR_W+1)'(2), count >= (ADDR_W+1)'(1)};
    assign head_p1 = head + ADDR_W'(1);

    assign slot0_entry = '{pc: bus.fetch_pc0, inst: bus.fetch_inst0,
                           exc: bus.fetch_exc0, cause: bus.fetch_cause0};
    assign slot1_entry = '{pc: bus.fetch_pc1, inst: bus.fetch_inst1,
                           exc: bus.fetch_exc1, cause: bus.fetch_cause1};

    // Push side: slot1 lands behind slot0 when both are valid, else at tail
    always_comb begin
        wr0_en   = ready && !bus.flush && bus.fetch_valid[0];
        wr1_en   = ready && !bus.flush && bus.fetch_valid[1];
        wr1_addr = bus.fetch_valid[0] ? tail + ADDR_W'(1) : tail;
        push_n   = {1'b0, wr0_en} + {1'b0, wr1_en};
    end

    // Pop side: slot1 may only be consumed together with slot0
    always_comb begin
        pop_n = 2'd0;
        if (!bus.flush) begin
            if (bus.deq_en == 2'b11 && valid == 2'b11) begin
                pop_n = 2'd2;
            end else if (bus.deq_en[0] && valid[0]) begin
                pop_n = 2'd1;
            end
        end
    end

    // Pointer and occupancy state; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ADDR_W'(pop_n);
            tail  <= tail + ADDR_W'(push_n);
            count <= count + (ADDR_W+1)'(push_n) - (ADDR_W+1)'(pop_n);
        end
    end

    ibuf_entry_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk      (clk),
        .wr0_en   (wr0_en),
        .wr0_addr (tail),
        .wr0_data (slot0_entry),
        .wr1_en   (wr1_en),
        .wr1_addr (wr1_addr),
        .wr1_data (slot1_entry),
        .rd0_addr (head),
        .rd0_data (rd0),
        .rd1_addr (head_p1),
        .rd1_data (rd1)
    );

    // Decode view: slots without a valid instruction show all-zero fields
    always_comb begin
        bus.ibuf_ready = ready;
        bus.out_valid  = valid;
        bus.out_pc0    = valid[0] ? rd0.pc    : '0;
        bus.out_inst0  = valid[0] ? rd0.inst  : '0;
        bus.out_exc0   = valid[0] ? rd0.exc   : 1'b0;
        bus.out_cause0 = valid[0] ? rd0.cause : '0;
        bus.out_pc1    = valid[1] ? rd1.pc    : '0;
        bus.out_inst1  = valid[1] ? rd1.inst  : '0;
        bus.out_exc1   = valid[1] ? rd1.exc   : 1'b0;
        bus.out_cause1 = valid[1] ? rd1.cause : '0;
    end

    // Occupancy never exceeds capacity and tail always trails head by count
    assert property (@(posedge clk) disable iff (rst)
        (count <= (ADDR_W+1)'(DEPTH)) && (tail == head + count[ADDR_W-1:0]));

endmodule

// File: tb/tb_inst_buffer_dual.sv
// Self-checking bench for inst_buffer_dual: directed scenarios followed by
// random traffic, compared against a queue-based model of the buffer.
module tb_inst_buffer_dual;
    import inst_buffer_dual_pkg::*;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
    } ent_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    ent_t model_q[$];
    logic [31:0] next_pc;

    inst_buffer_dual_if bus();

    inst_buffer_dual #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ent_t mkEnt(logic [31:0] pc, logic exc, logic [6:0] cause);
        ent_t e;
        e.pc    = pc;
        e.inst  = ~pc ^ 32'h02c0_0000;
        e.exc   = exc;
        e.cause = cause;
        return e;
    endfunction

    function automatic ent_t seqEnt();
        ent_t e;
        e = mkEnt(next_pc, 1'b0, 7'h00);
        next_pc = next_pc + 32'd4;
        return e;
    endfunction

    task automatic checkVal(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of fetch/decode/flush and advance the model with it
    task automatic applyStimulus(logic [1:0] fv, ent_t s0, ent_t s1,
                                 logic [1:0] deq, logic fl);
        int n;
        int pops;
        bus.fetch_valid  = fv;
        bus.fetch_pc0    = s0.pc;
        bus.fetch_inst0  = s0.inst;
        bus.fetch_exc0   = s0.exc;
        bus.fetch_cause0 = s0.cause;
        bus.fetch_pc1    = s1.pc;
        bus.fetch_inst1  = s1.inst;
        bus.fetch_exc1   = s1.exc;
        bus.fetch_cause1 = s1.cause;
        bus.deq_en       = deq;
        bus.flush        = fl;
        @(posedge clk);
        n = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (deq == 2'b11 && n >= 2)  pops = 2;
            else if (deq[0] && n >= 1)   pops = 1;
            else                         pops = 0;
            repeat (pops) void'(model_q.pop_front());
            if (n <= DEPTH - 2) begin
                if (fv[0]) model_q.push_back(s0);
                if (fv[1]) model_q.push_back(s1);
            end
        end
        #1;
    endtask

    // Compare every decode-side output with the model
    task automatic checkOutput(string tag);
        int   n;
        ent_t e0;
        ent_t e1;
        n  = model_q.size();
        e0 = (n >= 1) ? model_q[0] : '0;
        e1 = (n >= 2) ? model_q[1] : '0;
        checkVal({tag, ".valid"},  32'(bus.out_valid),  {30'd0, n >= 2, n >= 1});
        checkVal({tag, ".ready"},  32'(bus.ibuf_ready), 32'(n <= DEPTH - 2));
        checkVal({tag, ".pc0"},    bus.out_pc0,         e0.pc);
        checkVal({tag, ".inst0"},  bus.out_inst0,       e0.inst);
        checkVal({tag, ".exc0"},   32'(bus.out_exc0),   32'(e0.exc));
        checkVal({tag, ".cause0"}, 32'(bus.out_cause0), 32'(e0.cause));
        checkVal({tag, ".pc1"},    bus.out_pc1,         e1.pc);
        checkVal({tag, ".inst1"},  bus.out_inst1,       e1.inst);
        checkVal({tag, ".exc1"},   32'(bus.out_exc1),   32'(e1.exc));
        checkVal({tag, ".cause1"}, 32'(bus.out_cause1), 32'(e1.cause));
    endtask

    initial begin
        logic [6:0] codes [4];
        ent_t a;
        ent_t b;
        codes[0] = EXCEPTION_PIF;
        codes[1] = EXCEPTION_PPI;
        codes[2] = EXCEPTION_ADEF;
        codes[3] = EXCEPTION_TLBR;
        errors  = 0;
        checks  = 0;
        next_pc = 32'h1c00_0000;

        // Reset with all inputs quiet
        rst              = 1'b1;
        bus.flush        = 1'b0;
        bus.fetch_valid  = 2'b00;
        bus.deq_en       = 2'b00;
        bus.fetch_pc0    = '0;
        bus.fetch_pc1    = '0;
        bus.fetch_inst0  = '0;
        bus.fetch_inst1  = '0;
        bus.fetch_exc0   = 1'b0;
        bus.fetch_exc1   = 1'b0;
        bus.fetch_cause0 = '0;
        bus.fetch_cause1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_q.delete();
        checkOutput("reset");
        checkVal("reset_ready", 32'(bus.ibuf_ready), 32'd1);

        // Idle cycles leave the buffer empty
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, '0, '0, 2'b00, 1'b0);
            checkOutput("idle");
        end

        // Dual push, then dual pop
        a = seqEnt();
        b = seqEnt();
        applyStimulus(2'b11, a, b, 2'b00, 1'b0);
        checkOutput("pair_push");
        checkVal("pair_pc0", bus.out_pc0, 32'h1c00_0000);
        checkVal("pair_pc1", bus.out_pc1, 32'h1c00_0004);
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkOutput("pair_pop");
        checkVal("pair_pop_valid", 32'(bus.out_valid), 32'd0);

        // Fill to full; ready stays high through count 14, drops at 16
        for (int i = 0; i < 8; i++) begin
            a = seqEnt();
            b = seqEnt();
            applyStimulus(2'b11, a, b, 2'b00, 1'b0);
            checkOutput("fill");
        end
        checkVal("full_ready", 32'(bus.ibuf_ready), 32'd0);
        applyStimulus(2'b11, mkEnt(32'hdead_0000, 1'b0, 7'h0),
                      mkEnt(32'hdead_0004, 1'b0, 7'h0), 2'b00, 1'b0);
        checkOutput("full_ignore");
        applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
        checkOutput("drain15");
        checkVal("drain15_ready", 32'(bus.ibuf_ready), 32'd0);
        applyStimulus(2'b00, '0, '0, 2'b01, 1'b0);
        checkOutput("drain14");
        checkVal("drain14_ready", 32'(bus.ibuf_ready), 32'd1);
        while (model_q.size() > 0) begin
            applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
            checkOutput("drain");
        end

        // Streaming push+pop across pointer wrap keeps two entries queued
        a = seqEnt();
        b = seqEnt();
        applyStimulus(2'b11, a, b, 2'b00, 1'b0);
        checkOutput("wrap_prime");
        for (int i = 0; i < 20; i++) begin
            a = seqEnt();
            b = seqEnt();
            applyStimulus(2'b11, a, b, 2'b11, 1'b0);
            checkOutput("wrap");
            checkVal("wrap_seq", bus.out_pc1, bus.out_pc0 + 32'd4);
        end
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkOutput("wrap_drain");

        // Exception tag, slot1-only push, and a slot1-only dequeue
        applyStimulus(2'b01, mkEnt(32'h1c00_1000, 1'b1, EXCEPTION_ADEF), '0, 2'b00, 1'b0);
        checkOutput("exc_push");
        checkVal("exc_cause", 32'(bus.out_cause0), 32'h08);
        applyStimulus(2'b10, mkEnt(32'h1111_1111, 1'b0, 7'h0),
                      mkEnt(32'h1c00_2000, 1'b0, 7'h0), 2'b00, 1'b0);
        checkOutput("slot1_only");
        checkVal("slot1_pc", bus.out_pc1, 32'h1c00_2000);
        applyStimulus(2'b00, '0, '0, 2'b10, 1'b0);
        checkOutput("deq10");
        applyStimulus(2'b00, '0, '0, 2'b11, 1'b0);
        checkOutput("exc_drain");

        // Flush with five queued and same-cycle push/pop requests
        for (int i = 0; i < 2; i++) begin
            a = seqEnt();
            b = seqEnt();
            applyStimulus(2'b11, a, b, 2'b00, 1'b0);
        end
        applyStimulus(2'b01, seqEnt(), '0, 2'b00, 1'b0);
        checkOutput("pre_flush");
        a = seqEnt();
        b = seqEnt();
        applyStimulus(2'b11, a, b, 2'b11, 1'b1);
        checkOutput("flush");
        checkVal("flush_valid", 32'(bus.out_valid), 32'd0);
        applyStimulus(2'b01, mkEnt(32'h1c00_3000, 1'b0, 7'h0), '0, 2'b00, 1'b0);
        checkOutput("post_flush");
        checkVal("post_flush_pc0", bus.out_pc0, 32'h1c00_3000);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] fv;
            logic [1:0] deq;
            logic       fl;
            fv  = 2'($urandom_range(0, 3));
            deq = 2'($urandom_range(0, 3));
            fl  = ($urandom_range(0, 39) == 0);
            a = mkEnt($urandom, 1'($urandom_range(0, 1)), codes[$urandom_range(0, 3)]);
            b = mkEnt($urandom, 1'($urandom_range(0, 1)), codes[$urandom_range(0, 3)]);
            applyStimulus(fv, a, b, deq, fl);
            checkOutput("random");
        end

        // Reset mid-stream returns to empty
        applyStimulus(2'b11, seqEnt(), seqEnt(), 2'b00, 1'b0);
        rst = 1'b1;
        applyStimulus(2'b11, seqEnt(), seqEnt(), 2'b00, 1'b0);
        rst = 1'b0;
        model_q.delete();
        checkOutput("reset_again");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
